// File: rtl/jvs_feature_pkg.sv
// Shared types for the JVS feature-check (0x14) response parser.
// Holds the capability record layout, function codes, error codes and the record-apply helper.
package jvs_feature_pkg;

  // 116 information bits plus 12 reserved bits. The first field is the most significant.
  typedef struct packed {
    logic [3:0]  players;
    logic [7:0]  buttons;
    logic [3:0]  coin_slots;
    logic [3:0]  analog_ch;
    logic [7:0]  analog_bits;
    logic [3:0]  rotary_ch;
    logic        has_keycode;
    logic        has_screen_pos;
    logic [7:0]  scr_x_bits;
    logic [7:0]  scr_y_bits;
    logic [3:0]  scr_ch;
    logic [15:0] misc_digital;
    logic [3:0]  card_slots;
    logic [3:0]  hopper_ch;
    logic [7:0]  digital_outputs;
    logic [3:0]  analog_out_ch;
    logic        has_char_display;
    logic [7:0]  char_w;
    logic [7:0]  char_h;
    logic [7:0]  char_type;
    logic        has_backup;
    logic [11:0] reserved;
  } jvs_feat_t;

  localparam logic [7:0] FC_END     = 8'h00;
  localparam logic [7:0] FC_PLAYERS = 8'h01;
  localparam logic [7:0] FC_COIN    = 8'h02;
  localparam logic [7:0] FC_ANALOG  = 8'h03;
  localparam logic [7:0] FC_ROTARY  = 8'h04;
  localparam logic [7:0] FC_KEYCODE = 8'h05;
  localparam logic [7:0] FC_SCREEN  = 8'h06;
  localparam logic [7:0] FC_MISC    = 8'h07;
  localparam logic [7:0] FC_CARD    = 8'h10;
  localparam logic [7:0] FC_HOPPER  = 8'h11;
  localparam logic [7:0] FC_DOUT    = 8'h12;
  localparam logic [7:0] FC_AOUT    = 8'h13;
  localparam logic [7:0] FC_CHAR    = 8'h14;
  localparam logic [7:0] FC_BACKUP  = 8'h15;

  localparam logic [1:0] ERR_REPORT   = 2'd0;
  localparam logic [1:0] ERR_TRUNC    = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW = 2'd2;
  localparam logic [1:0] ERR_BAD_NODE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_REPORT, ST_CODE, ST_P1, ST_P2, ST_P3
  } parse_state_e;

  function automatic logic [3:0] sat4(input logic [7:0] v);
    return (v > 8'd15) ? 4'hF : v[3:0];
  endfunction

  // Unknown codes leave the record untouched; a repeated code simply overwrites.
  function automatic jvs_feat_t apply_record(input jvs_feat_t rec, input logic [7:0] code,
                                             input logic [7:0] p1, input logic [7:0] p2,
                                             input logic [7:0] p3);
    jvs_feat_t r;
    r = rec;
    case (code)
      FC_PLAYERS: begin r.players = sat4(p1); r.buttons = p2; end
      FC_COIN:    r.coin_slots = sat4(p1);
      FC_ANALOG:  begin r.analog_ch = sat4(p1); r.analog_bits = p2; end
      FC_ROTARY:  r.rotary_ch = sat4(p1);
      FC_KEYCODE: r.has_keycode = 1'b1;
      FC_SCREEN: begin
        r.has_screen_pos = 1'b1;
        r.scr_x_bits     = p1;
        r.scr_y_bits     = p2;
        r.scr_ch         = sat4(p3);
      end
      FC_MISC:    r.misc_digital = {p1, p2};
      FC_CARD:    r.card_slots = sat4(p1);
      FC_HOPPER:  r.hopper_ch = sat4(p1);
      FC_DOUT:    r.digital_outputs = p1;
      FC_AOUT:    r.analog_out_ch = sat4(p1);
      FC_CHAR: begin
        r.has_char_display = 1'b1;
        r.char_w           = p1;
        r.char_h           = p2;
        r.char_type        = p3;
      end
      FC_BACKUP:  r.has_backup = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jvs_feature_store.sv
// Per-node capability register file: atomic commit, global clear, valid bits
// and a registered read port.
module jvs_feature_store
  import jvs_feature_pkg::*;
#(
  parameter int MAX_NODES  = 4,
  parameter int NODE_IDX_W = $clog2(MAX_NODES > 1 ? MAX_NODES : 2)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_all_i,
  input  logic                  commit_i,
  input  logic [NODE_IDX_W-1:0] commit_node_i,
  input  jvs_feat_t             commit_rec_i,
  input  logic [NODE_IDX_W-1:0] rd_node_i,
  output logic [MAX_NODES-1:0]  node_valid_o,
  output jvs_feat_t             rd_info_o
);

  jvs_feat_t            rec_q [MAX_NODES];
  logic [MAX_NODES-1:0] valid_q;
  jvs_feat_t            rd_q;

  // Clear has priority over a commit landing in the same cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i || clr_all_i) begin
      for (int n = 0; n < MAX_NODES; n++) rec_q[n] <= '0;
      valid_q <= '0;
      rd_q    <= '0;
    end else begin
      if (commit_i) begin
        rec_q[commit_node_i]   <= commit_rec_i;
        valid_q[commit_node_i] <= 1'b1;
      end
      rd_q <= (int'(rd_node_i) < MAX_NODES) ? rec_q[rd_node_i] : '0;
    end
  end

  assign node_valid_o = valid_q;
  assign rd_info_o    = rd_q;

endmodule

// File: rtl/jvs_feature_parser.sv
// Byte-serial parser for the JVS feature-check response. Builds a shadow record
// and commits it to the node store only when the end code arrives cleanly.
module jvs_feature_parser
  import jvs_feature_pkg::*;
#(
  parameter int MAX_NODES   = 4,
  parameter int MAX_RECORDS = 16,
  parameter int NODE_IDX_W  = $clog2(MAX_NODES > 1 ? MAX_NODES : 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_all,
  input  logic                  start,
  input  logic [NODE_IDX_W-1:0] start_node,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  input  logic                  byte_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [MAX_NODES-1:0]  node_valid,
  input  logic [NODE_IDX_W-1:0] rd_node,
  output logic [127:0]          rd_info,
  output logic [2:0]            dbg_state
);

  localparam int CNT_W = $clog2(MAX_RECORDS + 1);

  // Byte strobes are one-cycle valid with no backpressure: each asserted
  // byte_valid cycle consumes exactly one payload byte, and start is only
  // honoured while the parser is idle.
  parse_state_e          state_q, state_d;
  jvs_feat_t             shadow_q, shadow_d;
  logic [7:0]            code_q, code_d, p1_q, p1_d, p2_q, p2_d;
  logic [NODE_IDX_W-1:0] node_q, node_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d, err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;
  logic                  commit, fail;
  logic [1:0]            fail_code;
  jvs_feat_t             rd_rec;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_all) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      code_q     <= '0;
      p1_q       <= '0;
      p2_q       <= '0;
      node_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      code_q     <= code_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      node_q     <= node_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    code_d     = code_q;
    p1_d       = p1_q;
    p2_d       = p2_q;
    node_d     = node_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = 2'd0;
    commit     = 1'b0;
    fail       = 1'b0;
    fail_code  = 2'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (int'(start_node) < MAX_NODES) begin
            shadow_d = '0;
            cnt_d    = '0;
            node_d   = start_node;
            state_d  = ST_REPORT;
          end else begin
            done_d     = 1'b1;
            err_d      = 1'b1;
            err_code_d = ERR_BAD_NODE;
          end
        end
      end
      ST_REPORT: if (byte_valid) begin
        if (byte_data != 8'h01) begin
          fail = 1'b1; fail_code = ERR_REPORT;
        end else if (byte_last) begin
          fail = 1'b1; fail_code = ERR_TRUNC;
        end else begin
          state_d = ST_CODE;
        end
      end
      ST_CODE: if (byte_valid) begin
        // A non-zero code after a full table is reported as overflow even if it is also last.
        if (byte_data == FC_END) begin
          commit  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (int'(cnt_q) == MAX_RECORDS) begin
          fail = 1'b1; fail_code = ERR_OVERFLOW;
        end else if (byte_last) begin
          fail = 1'b1; fail_code = ERR_TRUNC;
        end else begin
          code_d  = byte_data;
          state_d = ST_P1;
        end
      end
      ST_P1: if (byte_valid) begin
        if (byte_last) begin
          fail = 1'b1; fail_code = ERR_TRUNC;
        end else begin
          p1_d = byte_data; state_d = ST_P2;
        end
      end
      ST_P2: if (byte_valid) begin
        if (byte_last) begin
          fail = 1'b1; fail_code = ERR_TRUNC;
        end else begin
          p2_d = byte_data; state_d = ST_P3;
        end
      end
      ST_P3: if (byte_valid) begin
        if (byte_last) begin
          fail = 1'b1; fail_code = ERR_TRUNC;
        end else begin
          shadow_d = apply_record(shadow_q, code_q, p1_q, p2_q, byte_data);
          cnt_d    = cnt_q + CNT_W'(1);
          state_d  = ST_CODE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fail) begin
      state_d    = ST_IDLE;
      done_d     = 1'b1;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end
  end

  jvs_feature_store #(
    .MAX_NODES  (MAX_NODES),
    .NODE_IDX_W (NODE_IDX_W)
  ) u_store (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .clr_all_i     (clr_all),
    .commit_i      (commit),
    .commit_node_i (node_q),
    .commit_rec_i  (shadow_q),
    .rd_node_i     (rd_node),
    .node_valid_o  (node_valid),
    .rd_info_o     (rd_rec)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign rd_info   = rd_rec;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_jvs_feature_parser.sv
// Bench for jvs_feature_parser: directed corner cases, a field-mapping table and
// randomized packets checked against a per-code last-write model.
module tb_jvs_feature_parser;

  localparam int MAX_NODES   = 3;
  localparam int MAX_RECORDS = 4;
  localparam int NW          = 2;

  logic                 clk = 1'b0;
  logic                 rst_n, clr_all, start, byte_valid, byte_last;
  logic [NW-1:0]        start_node, rd_node;
  logic [7:0]           byte_data;
  logic                 busy, done, err;
  logic [1:0]           err_code;
  logic [MAX_NODES-1:0] node_valid;
  logic [127:0]         rd_info;
  logic [2:0]           dbg_state;

  jvs_feature_parser #(.MAX_NODES(MAX_NODES), .MAX_RECORDS(MAX_RECORDS)) dut (
    .clk(clk), .rst_n(rst_n), .clr_all(clr_all), .start(start), .start_node(start_node),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .node_valid(node_valid),
    .rd_node(rd_node), .rd_info(rd_info), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int                   checks = 0;
  int                   failures = 0;
  logic [127:0]         exp_rec [MAX_NODES];
  logic [MAX_NODES-1:0] exp_valid;
  logic [2:0]           exp_q[$];
  logic [7:0]           pkt_b[$];
  bit                   pkt_l[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp_v);
    end
  endtask

  // Field placement: record bit 127 is the first field (players).
  function automatic logic [127:0] fld(input int lsb, input int v);
    return 128'(v) << lsb;
  endfunction

  function automatic int s4(input logic [7:0] v);
    return (v > 8'd15) ? 15 : int'(v);
  endfunction

  // Walks the packet by the protocol rules; keeps the last parameters seen per code.
  function automatic void model(input int n, output int idx, output logic e,
                                output logic [1:0] ec, output logic [127:0] rec);
    logic [7:0] pv [256][3];
    bit         seen [256];
    int         recs, i;
    bit         stop;
    idx = -1; e = 1'b0; ec = 2'd0; rec = '0; recs = 0; stop = 0;
    for (int c = 0; c < 256; c++) seen[c] = 0;
    if (n == 0) return;
    if (pkt_b[0] != 8'h01) begin idx = 0; e = 1'b1; ec = 2'd0; return; end
    if (pkt_l[0]) begin idx = 0; e = 1'b1; ec = 2'd1; return; end
    i = 1;
    while (i < n && !stop) begin
      if (pkt_b[i] == 8'h00) begin idx = i; stop = 1; end
      else if (recs == MAX_RECORDS) begin idx = i; e = 1'b1; ec = 2'd2; return; end
      else if (pkt_l[i]) begin idx = i; e = 1'b1; ec = 2'd1; return; end
      else begin
        for (int k = 1; k <= 3; k++) begin
          if (i + k >= n) return;
          if (pkt_l[i + k]) begin idx = i + k; e = 1'b1; ec = 2'd1; return; end
        end
        seen[pkt_b[i]] = 1;
        for (int k = 0; k < 3; k++) pv[pkt_b[i]][k] = pkt_b[i + 1 + k];
        recs++;
        i += 4;
      end
    end
    if (idx < 0) return;
    if (seen[8'h01]) rec |= fld(124, s4(pv[8'h01][0])) | fld(116, pv[8'h01][1]);
    if (seen[8'h02]) rec |= fld(112, s4(pv[8'h02][0]));
    if (seen[8'h03]) rec |= fld(108, s4(pv[8'h03][0])) | fld(100, pv[8'h03][1]);
    if (seen[8'h04]) rec |= fld(96, s4(pv[8'h04][0]));
    if (seen[8'h05]) rec |= fld(95, 1);
    if (seen[8'h06]) rec |= fld(94, 1) | fld(86, pv[8'h06][0]) | fld(78, pv[8'h06][1])
                          | fld(74, s4(pv[8'h06][2]));
    if (seen[8'h07]) rec |= fld(58, {pv[8'h07][0], pv[8'h07][1]});
    if (seen[8'h10]) rec |= fld(54, s4(pv[8'h10][0]));
    if (seen[8'h11]) rec |= fld(50, s4(pv[8'h11][0]));
    if (seen[8'h12]) rec |= fld(42, pv[8'h12][0]);
    if (seen[8'h13]) rec |= fld(38, s4(pv[8'h13][0]));
    if (seen[8'h14]) rec |= fld(37, 1) | fld(29, pv[8'h14][0]) | fld(21, pv[8'h14][1])
                          | fld(13, pv[8'h14][2]);
    if (seen[8'h15]) rec |= fld(12, 1);
  endfunction

  task automatic set_pkt(input logic [7:0] b[$]);
    pkt_b = b;
    pkt_l.delete();
    foreach (b[i]) pkt_l.push_back(i == b.size() - 1);
  endtask

  task automatic readback(input string tag);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); rd_node = k[NW-1:0];
      @(negedge clk);
      if (k < MAX_NODES) chk({tag, " rd_info"}, rd_info, exp_rec[k]);
      else               chk({tag, " rd_info_oob"}, rd_info, '0);
    end
    chk({tag, " node_valid"}, node_valid, exp_valid);
  endtask

  task automatic run_pkt(input int node, input string tag);
    int n, eidx, gidx; logic ee; logic [1:0] eec; logic [127:0] erec; logic [2:0] got;
    n = pkt_b.size();
    @(negedge clk);
    start = 1'b1; start_node = node[NW-1:0];
    if ($urandom_range(0, 1) == 1) begin
      byte_valid = 1'b1; byte_data = 8'($urandom_range(0, 255)); byte_last = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0; byte_last = 1'b0;
    if (node >= MAX_NODES) begin
      exp_q.push_back({1'b1, 2'd3});
      chk({tag, " bad_node done"}, done, 1);
      chk({tag, " bad_node outcome"}, {err, err_code}, exp_q.pop_front());
      chk({tag, " bad_node busy"}, busy, 0);
      @(negedge clk);
      chk({tag, " bad_node pulse"}, done, 0);
      return;
    end
    chk({tag, " busy_after_start"}, busy, 1);
    model(n, eidx, ee, eec, erec);
    exp_q.push_back({ee, eec});
    gidx = -1; got = '0;
    for (int i = 0; i < n && gidx < 0; i++) begin
      byte_valid = 1'b1; byte_data = pkt_b[i]; byte_last = pkt_l[i];
      @(negedge clk);
      byte_valid = 1'b0; byte_last = 1'b0;
      if (done) begin
        gidx = i; got = {err, err_code};
        chk({tag, " busy_at_done"}, busy, 0);
      end else if ($urandom_range(0, 3) == 0) begin
        start = 1'b1; start_node = NW'($urandom_range(0, 3));
        @(negedge clk);
        start = 1'b0;
        if (done) gidx = 1000;
      end
    end
    chk({tag, " done_index"}, 128'(gidx), 128'(eidx));
    chk({tag, " outcome"}, got, exp_q.pop_front());
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    if (eidx >= 0 && !ee) begin
      exp_rec[node] = erec;
      exp_valid[node] = 1'b1;
    end
    readback(tag);
  endtask

  typedef struct {
    logic [7:0]   c, p1, p2, p3;
    logic [127:0] exp_v;
  } vec_t;
  vec_t tbl [14];

  initial begin
    logic [7:0] q[$];
    rst_n = 1'b0; clr_all = 1'b0; start = 1'b0; start_node = '0;
    byte_valid = 1'b0; byte_data = '0; byte_last = 1'b0; rd_node = '0;
    for (int k = 0; k < MAX_NODES; k++) exp_rec[k] = '0;
    exp_valid = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset outputs", {busy, done, err, err_code, dbg_state}, '0);
    chk("reset node_valid", node_valid, '0);
    chk("reset rd_info", rd_info, '0);

    set_pkt('{8'h01, 8'h01, 8'h02, 8'h0D, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00,
              8'h03, 8'h08, 8'h0A, 8'h00, 8'h00});
    run_pkt(0, "basic");
    @(negedge clk); rd_node = 0;
    @(negedge clk);
    chk("basic fields", rd_info, fld(124, 2) | fld(116, 13) | fld(112, 2) | fld(108, 8) | fld(100, 10));
    chk("basic node_valid", node_valid, 3'b001);
    for (int i = 0; i < 3; i++) begin
      byte_valid = 1'b1; byte_data = (i == 2) ? 8'h00 : 8'h01; byte_last = (i == 2);
      @(negedge clk);
      byte_valid = 1'b0; byte_last = 1'b0;
      chk("ignored_after_end", {busy, done}, 2'b00);
    end

    set_pkt('{8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00});
    run_pkt(1, "bad_report");
    chk("bad_report node1 invalid", node_valid[1], 0);

    set_pkt('{8'h01, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00});
    run_pkt(2, "node2_first");
    set_pkt('{8'h01, 8'h01, 8'h02, 8'h0D});
    run_pkt(2, "truncated");
    chk("truncated preserved", exp_rec[2], fld(96, 5));

    q = '{8'h01};
    for (int r = 0; r < MAX_RECORDS; r++) q = {q, 8'h01, 8'h01, 8'h01, 8'h01};
    q = {q, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00};
    set_pkt(q);
    run_pkt(1, "overflow");

    pkt_b.delete(); pkt_l.delete();
    run_pkt(3, "bad_node");

    @(negedge clk); start = 1'b1; start_node = 2'd2;
    @(negedge clk); start = 1'b0; byte_valid = 1'b1; byte_data = 8'h01;
    @(negedge clk); byte_data = 8'h05;
    @(negedge clk); byte_valid = 1'b0; clr_all = 1'b1;
    @(negedge clk); clr_all = 1'b0;
    chk("clr busy", busy, 0);
    chk("clr node_valid", node_valid, '0);
    for (int i = 0; i < 3; i++) begin
      chk("clr no_done", done, 0);
      @(negedge clk);
    end
    for (int k = 0; k < MAX_NODES; k++) exp_rec[k] = '0;
    exp_valid = '0;
    readback("clr");

    tbl[0]  = '{8'h01, 8'h14, 8'h20, 8'h00, fld(124, 15) | fld(116, 'h20)};
    tbl[1]  = '{8'h07, 8'h01, 8'h00, 8'h00, fld(58, 'h100)};
    tbl[2]  = '{8'h15, 8'h00, 8'h00, 8'h00, fld(12, 1)};
    tbl[3]  = '{8'h06, 8'h0C, 8'h30, 8'h02, fld(94, 1) | fld(86, 'h0C) | fld(78, 'h30) | fld(74, 2)};
    tbl[4]  = '{8'h14, 8'h10, 8'h05, 8'hFF, fld(37, 1) | fld(29, 'h10) | fld(21, 5) | fld(13, 'hFF)};
    tbl[5]  = '{8'h04, 8'hFF, 8'h00, 8'h00, fld(96, 15)};
    tbl[6]  = '{8'h12, 8'hAB, 8'h00, 8'h00, fld(42, 'hAB)};
    tbl[7]  = '{8'h13, 8'h0F, 8'h00, 8'h00, fld(38, 15)};
    tbl[8]  = '{8'h10, 8'h02, 8'h00, 8'h00, fld(54, 2)};
    tbl[9]  = '{8'h11, 8'h10, 8'h00, 8'h00, fld(50, 15)};
    tbl[10] = '{8'h05, 8'h00, 8'h00, 8'h00, fld(95, 1)};
    tbl[11] = '{8'h09, 8'h11, 8'h22, 8'h33, '0};
    tbl[12] = '{8'h02, 8'h1F, 8'h00, 8'h00, fld(112, 15)};
    tbl[13] = '{8'h03, 8'h20, 8'h0C, 8'h00, fld(108, 15) | fld(100, 12)};
    for (int t = 0; t < 14; t++) begin
      set_pkt('{8'h01, tbl[t].c, tbl[t].p1, tbl[t].p2, tbl[t].p3, 8'h00});
      run_pkt(1, "table");
      @(negedge clk); rd_node = 2'd1;
      @(negedge clk);
      chk($sformatf("table[%0d] record", t), rd_info, tbl[t].exp_v);
    end

    for (int t = 0; t < 150; t++) begin
      logic [7:0] codes [16];
      int nrec, n, node;
      codes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10,
                8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h08, 8'h20, 8'hFF};
      q = '{($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'h01};
      nrec = $urandom_range(0, MAX_RECORDS + 2);
      for (int r = 0; r < nrec; r++) begin
        q.push_back(codes[$urandom_range(0, 15)]);
        for (int k = 0; k < 3; k++)
          q.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 31)));
      end
      q.push_back(8'h00);
      if ($urandom_range(0, 4) == 0) begin
        n = $urandom_range(1, q.size());
        while (q.size() > n) void'(q.pop_back());
      end
      set_pkt(q);
      node = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, MAX_NODES - 1);
      run_pkt(node, $sformatf("rand[%0d]", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
